// File: rtl/sort_result_collector.sv
// Captures one N_ELEMS-word serial frame after a ready_i rising edge and keeps it.
// Reports ordering, min/max and the arm-to-first-word latency, with indexed readback.
module sort_result_collector #(
  parameter int N_ELEMS = 10,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        ready_i,
  input  logic signed [DATA_W-1:0]    data_serial_i,
  input  logic [$clog2(N_ELEMS)-1:0]  rd_idx_i,
  output logic signed [DATA_W-1:0]    rd_data_o,
  output logic                        done_o,
  output logic                        sorted_ok_o,
  output logic [$clog2(N_ELEMS)-1:0]  err_idx_o,
  output logic signed [DATA_W-1:0]    min_o,
  output logic signed [DATA_W-1:0]    max_o,
  output logic [CNT_W-1:0]            cycles_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(N_ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_ready_q;
  logic                      w_ready_rise;
  logic [IDX_W-1:0]          r_idx;
  logic signed [DATA_W-1:0]  r_prev;
  logic signed [DATA_W-1:0]  r_buf [N_ELEMS];
  logic                      r_ok;
  logic [IDX_W-1:0]          r_err_idx;
  logic signed [DATA_W-1:0]  r_min;
  logic signed [DATA_W-1:0]  r_max;
  logic [CNT_W-1:0]          r_cycles;
  logic signed [DATA_W-1:0]  w_rd_data;

  assign w_ready_rise = ready_i & ~r_ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start_i wins over everything, including a ready edge
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next_state = S_ARMED;
        else         w_next_state = S_IDLE;
      end
      S_ARMED: begin
        if (start_i)           w_next_state = S_ARMED;
        else if (w_ready_rise) w_next_state = S_CAPTURE;
        else                   w_next_state = S_ARMED;
      end
      S_CAPTURE: begin
        if (start_i)                w_next_state = S_ARMED;
        else if (r_idx == LAST_IDX) w_next_state = S_DONE;
        else                        w_next_state = S_CAPTURE;
      end
      S_DONE: begin
        if (start_i) w_next_state = S_ARMED;
        else         w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture datapath: buffer, order check, min/max, latency counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready_q <= 1'b0;
      r_idx     <= '0;
      r_prev    <= '0;
      r_ok      <= 1'b0;
      r_err_idx <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_cycles  <= '0;
      for (int i = 0; i < N_ELEMS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_ready_q <= ready_i;
      if (start_i) begin
        r_idx     <= '0;
        r_prev    <= '0;
        r_ok      <= 1'b0;
        r_err_idx <= '0;
        r_min     <= '0;
        r_max     <= '0;
        r_cycles  <= '0;
      end else begin
        case (r_state)
          S_ARMED: begin
            if (r_cycles != {CNT_W{1'b1}}) begin
              r_cycles <= r_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_ready_rise) begin
              r_buf[0]  <= data_serial_i;
              r_prev    <= data_serial_i;
              r_min     <= data_serial_i;
              r_max     <= data_serial_i;
              r_ok      <= 1'b1;
              r_err_idx <= '0;
              r_idx     <= {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
          S_CAPTURE: begin
            r_buf[r_idx] <= data_serial_i;
            r_prev       <= data_serial_i;
            // Only the first descent is recorded; equal neighbours count as ordered
            if (r_ok && (data_serial_i < r_prev)) begin
              r_ok      <= 1'b0;
              r_err_idx <= r_idx;
            end
            if (data_serial_i < r_min) r_min <= data_serial_i;
            if (data_serial_i > r_max) r_max <= data_serial_i;
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Readback mux; indices beyond the frame read as zero
  always_comb begin
    w_rd_data = '0;
    if (32'(rd_idx_i) < N_ELEMS) begin
      w_rd_data = r_buf[rd_idx_i];
    end else begin
      w_rd_data = '0;
    end
  end

  assign rd_data_o   = w_rd_data;
  assign done_o      = (r_state == S_DONE);
  assign busy_o      = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign sorted_ok_o = r_ok;
  assign err_idx_o   = r_err_idx;
  assign min_o       = r_min;
  assign max_o       = r_max;
  assign cycles_o    = r_cycles;

endmodule

// File: doc/sort_result_collector.md
SORT_RESULT_COLLECTOR -- requirements
Module: sort_result_collector

Interface
REQ-001 The block SHALL have parameter N_ELEMS, default 10, meaning the number of words per frame.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of one signed word.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the cycle counter.
REQ-004 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, the reset: synchronous, active-low.
REQ-006 The block SHALL have port start_i, input, 1, which arms the block and clears the previous result.
REQ-007 The block SHALL have port ready_i, input, 1, the sorter's result-ready flag.
REQ-008 The block SHALL have port data_serial_i, input, DATA_W, the signed serial result word.
REQ-009 The block SHALL have port rd_idx_i, input, clog2(N_ELEMS), the readout index.
REQ-010 The block SHALL have port rd_data_o, output, DATA_W, the captured word at rd_idx_i.
REQ-011 The block SHALL have port done_o, output, 1, which is high while a complete frame is held.
REQ-012 The block SHALL have port sorted_ok_o, output, 1, which is high when the frame is non-decreasing (signed); valid only while done_o is high.
REQ-013 The block SHALL have port err_idx_o, output, clog2(N_ELEMS), the index of the first word less than its predecessor (0 if none).
REQ-014 The block SHALL have ports min_o and max_o, output, DATA_W each, the signed minimum and maximum of the frame.
REQ-015 The block SHALL have port cycles_o, output, CNT_W, the number of cycles from arm to the first captured word.
REQ-016 The block SHALL have port busy_o, output, 1, which is high in ARMED or CAPTURE.

Function
REQ-017 The block SHALL implement an FSM with the states IDLE, ARMED, CAPTURE and DONE.
REQ-018 In IDLE, start_i=1 SHALL move the FSM to ARMED and clear cycles_o, the flags and the index counter.
REQ-019 In ARMED, cycles_o SHALL increment once per cycle and saturate at 2^CNT_W-1.
REQ-020 In ARMED, a rising edge of ready_i (registered previous value 0, current value 1) SHALL capture data_serial_i as word 0 in the same cycle and move the FSM to CAPTURE.
REQ-021 In CAPTURE, the block SHALL capture one word per cycle, so that words 0..N_ELEMS-1 are taken on N_ELEMS consecutive clocks, ignoring ready_i.
REQ-022 The block SHALL write each word k into its buffer, compare it signed against word k-1 for k>=1, and latch the first k with word[k]<word[k-1] into err_idx_o while clearing the ok flag.
REQ-023 Equal adjacent words SHALL be treated as ordered.
REQ-024 min_o and max_o SHALL be initialised from word 0 and updated with a signed compare on every subsequent word.
REQ-025 After word N_ELEMS-1 is captured, the FSM SHALL enter DONE on the next clock, with done_o=1 and all result outputs stable.
REQ-026 In DONE, the block SHALL ignore ready_i; start_i=1 SHALL re-arm the block (DONE -> ARMED) with outputs cleared.
REQ-027 start_i=1 in ARMED or CAPTURE SHALL abort the current frame and restart ARMED with cycles_o=0; start_i SHALL take priority over a simultaneous ready_i edge.
REQ-028 If ready_i is already high when the block arms, no capture SHALL occur until ready_i falls and rises again.
REQ-029 rd_data_o SHALL be a combinational read of the buffer, valid in any state; entries not yet written since reset SHALL read 0.
REQ-030 The 0 -> N_ELEMS-1 index counter SHALL not wrap in CAPTURE; the CAPTURE -> DONE transition terminates it.

Reset
REQ-031 rst=0 at a rising clk edge SHALL force IDLE and set done_o, busy_o, sorted_ok_o, err_idx_o, min_o, max_o, cycles_o and all buffer entries to 0, together with the registered ready_i history.
REQ-032 rst=0 asserted mid-CAPTURE SHALL discard the partial frame; the first clock after release SHALL be in IDLE.

Verification
REQ-033 The bench SHALL cover: start, 5 idle cycles, ready_i rise, then -881,-347,-347,-281,0,203,345,383,570,797 -> done_o=1, sorted_ok_o=1, err_idx_o=0, min_o=-881, max_o=797, cycles_o=6.
REQ-034 The bench SHALL cover: the same frame with words 4 and 5 swapped (203,0) -> sorted_ok_o=0, err_idx_o=5.
REQ-035 The bench SHALL cover: ten words of 570 -> sorted_ok_o=1, min_o=max_o=570; rd_idx_i 0..9 -> 570 each.
REQ-036 The bench SHALL cover: rst=0 after 4 captured words, then release -> IDLE, all outputs 0, rd_data_o=0 at every index.
REQ-037 The bench SHALL cover: ready_i held high through start, no fall -> stays ARMED and cycles_o keeps counting; after a fall then rise -> capture begins.
REQ-038 The bench SHALL cover: start_i pulse during CAPTURE at word 3 -> busy_o=1, cycles_o=0, and the next ready_i rise captures a fresh frame that is fully correct.
